// File: rtl/decode_queue.sv
// decode_queue: fetch-to-issue instruction buffer with a MIPS32 main decoder.
// Up to FETCH_W instructions are decoded and written per cycle into a circular
// FIFO of DEPTH entries. Each entry holds instr, pc and a 15-bit control word.
// The oldest ISSUE_W entries are presented to issue every cycle.
// Optional feature macro: DECODE_MUL_EN (SPECIAL2 MUL decodes as a register write).
module decode_queue #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [FETCH_W-1:0]                 fetch_valid,
  input  logic [32*FETCH_W-1:0]              fetch_instr,
  input  logic [32*FETCH_W-1:0]              fetch_pc,
  output logic                               fetch_ready,
  output logic [ISSUE_W-1:0]                 issue_valid,
  output logic [32*ISSUE_W-1:0]              issue_instr,
  output logic [32*ISSUE_W-1:0]              issue_pc,
  output logic [15*ISSUE_W-1:0]              issue_ctrl,
  input  logic [$clog2(ISSUE_W+1)-1:0]       issue_cnt,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int PUSH_W = $clog2(FETCH_W+1);

  // Opcodes used by the decoder.
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // Decode a single instruction into the packed control word:
  // {regwrite, regdst[1:0], is_imm, memtoreg, mem_read, mem_write,
  //  sign_ex, ri, brk, sys, eret, br_judge[2:0]}
  function automatic logic [14:0] decodeCtrl(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       regWrite;
    logic [1:0] regDst;
    logic       isImm;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       signEx;
    logic       ri;
    logic       brk;
    logic       sys;
    logic       eret;
    logic [2:0] brJudge;
    op       = instr[31:26];
    rs       = instr[25:21];
    rt       = instr[20:16];
    funct    = instr[5:0];
    regWrite = 1'b0;
    regDst   = 2'b00;
    isImm    = 1'b0;
    memToReg = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    ri       = 1'b0;
    brk      = 1'b0;
    sys      = 1'b0;
    eret     = 1'b0;
    brJudge  = 3'b000;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          // ALU register ops, shifts, MFHI/MFLO
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011,
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010: regWrite = 1'b1;
          // JR, MULT(U), DIV(U), MTHI, MTLO: no register write
          6'b001000, 6'b011000, 6'b011001, 6'b011010,
          6'b011011, 6'b010001, 6'b010011: ;
          6'b001001: begin // JALR
            regWrite = 1'b1;
            regDst   = 2'b10;
          end
          6'b001100: sys = 1'b1;  // SYSCALL
          6'b001101: brk = 1'b1;  // BREAK
          default:   ri  = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        // Every REGIMM encoding gets a branch condition; unknown rt is also
        // flagged reserved.
        case (rt)
          5'b00000: brJudge = 3'b101; // BLTZ
          5'b00001: brJudge = 3'b110; // BGEZ
          5'b10000: begin             // BLTZAL
            brJudge  = 3'b101;
            regWrite = 1'b1;
            regDst   = 2'b10;
          end
          5'b10001: begin             // BGEZAL
            brJudge  = 3'b110;
            regWrite = 1'b1;
            regDst   = 2'b10;
          end
          default: begin
            brJudge = 3'b101;
            ri      = 1'b1;
          end
        endcase
      end
      OP_J: ;
      OP_JAL: begin
        regWrite = 1'b1;
        regDst   = 2'b10;
      end
      OP_BEQ:  brJudge = 3'b001;
      OP_BNE:  brJudge = 3'b010;
      OP_BLEZ: brJudge = 3'b011;
      OP_BGTZ: brJudge = 3'b100;
      // ADDI(U), SLTI(U), ANDI, ORI, XORI, LUI
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        regWrite = 1'b1;
        regDst   = 2'b01;
        isImm    = 1'b1;
      end
      // LB, LH, LW, LBU, LHU
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        regWrite = 1'b1;
        regDst   = 2'b01;
        isImm    = 1'b1;
        memToReg = 1'b1;
        memRead  = 1'b1;
      end
      // SB, SH, SW
      6'b101000, 6'b101001, 6'b101011: begin
        isImm    = 1'b1;
        memWrite = 1'b1;
      end
      OP_COP0: begin
        if (instr == ERET_WORD) begin
          eret = 1'b1;
        end else if (rs == 5'b00000) begin // MFC0
          regWrite = 1'b1;
          regDst   = 2'b01;
        end else if (rs == 5'b00100) begin // MTC0
        end else begin
          ri = 1'b1;
        end
      end
      OP_SPECIAL2: begin
`ifdef DECODE_MUL_EN
        if (funct == 6'b000010) begin // MUL rd, rs, rt
          regWrite = 1'b1;
        end else begin
          ri = 1'b1;
        end
`else
        ri = 1'b1;
`endif
      end
      default: ri = 1'b1;
    endcase
    // Logical immediates (ANDI/ORI/XORI/LUI group) zero-extend; all else sign-extends.
    signEx = (op[5:2] != 4'b0011);
    return {regWrite, regDst, isImm, memToReg, memRead, memWrite,
            signEx, ri, brk, sys, eret, brJudge};
  endfunction

  // Length of the contiguous run of valid slots starting at slot 0.
  function automatic logic [PUSH_W-1:0] leadingOnes(input logic [FETCH_W-1:0] v);
    logic [PUSH_W-1:0] n;
    logic              run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (run && v[i]) begin
        n = n + PUSH_W'(1);
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] pushCnt;
  logic [CNT_W-1:0] availCnt;
  logic [CNT_W-1:0] npop;

  logic [14:0] decCtrl_p0 [FETCH_W];

  logic [31:0] instrMem_p1 [DEPTH];
  logic [31:0] pcMem_p1    [DEPTH];
  logic [14:0] ctrlMem_p1  [DEPTH];

  // ---- stage p0: decode fetch slots combinationally ----
  for (genvar g = 0; g < FETCH_W; g++) begin : gDecode
    assign decCtrl_p0[g] = decodeCtrl(fetch_instr[32*g +: 32]);
  end

  // Admission uses occupancy before this cycle's pop, so it never depends on issue.
  assign fetch_ready = (count <= CNT_W'(DEPTH - FETCH_W));

  // Push and pop amounts for this cycle; pop is clamped to what is presented.
  always_comb begin
    pushCnt  = fetch_ready ? CNT_W'(leadingOnes(fetch_valid)) : '0;
    availCnt = (count > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : count;
    npop     = (CNT_W'(issue_cnt) > availCnt) ? availCnt : CNT_W'(issue_cnt);
  end

  // ---- stage p1: FIFO storage, written at tail with decoded entries ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem_p1[i] <= '0;
        pcMem_p1[i]    <= '0;
        ctrlMem_p1[i]  <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(pushCnt)) begin
          instrMem_p1[tail + PTR_W'(i)] <= fetch_instr[32*i +: 32];
          pcMem_p1[tail + PTR_W'(i)]    <= fetch_pc[32*i +: 32];
          ctrlMem_p1[tail + PTR_W'(i)]  <= decCtrl_p0[i];
        end
      end
    end
  end

  // Pointer and occupancy update; full vs. empty is told apart by count alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(npop);
      tail  <= tail + PTR_W'(pushCnt);
      count <= count + pushCnt - npop;
    end
  end

  // Issue window: oldest ISSUE_W entries, valid as a thermometer code.
  for (genvar g = 0; g < ISSUE_W; g++) begin : gIssue
    logic [PTR_W-1:0] rdIdx;
    assign rdIdx                  = head + PTR_W'(g);
    assign issue_valid[g]         = (count > CNT_W'(g));
    assign issue_instr[32*g +: 32] = instrMem_p1[rdIdx];
    assign issue_pc[32*g +: 32]    = pcMem_p1[rdIdx];
    assign issue_ctrl[15*g +: 15]  = ctrlMem_p1[rdIdx];
  end

`ifndef SYNTHESIS
  // Flag issue requests that exceed the presented entries (they are clamped).
  always_ff @(posedge clk) begin
    if (!rst && !flush && (CNT_W'(issue_cnt) > availCnt)) begin
      $error("decode_queue: issue_cnt %0d exceeds available %0d", issue_cnt, availCnt);
    end
  end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: scoreboard of expected entries (instr, pc, ctrl),
// pushed when fetch is accepted and popped when issue consumes.
module tb_decode_queue;

  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  fetch_valid;
  logic [63:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        fetch_ready;
  logic [1:0]  issue_valid;
  logic [63:0] issue_instr;
  logic [63:0] issue_pc;
  logic [29:0] issue_ctrl;
  logic [1:0]  issue_cnt;
  logic [3:0]  count;

  decode_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_ctrl(issue_ctrl), .issue_cnt(issue_cnt), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [14:0] ctrl;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] tabI [16];
  logic [14:0] tabC [16];
  logic [31:0] pcNext;
  int          nChecks = 0;
  int          nErrors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: check outputs of the previous edge, drive new inputs, advance model.
  task automatic cycle(input logic [1:0] fv, input int i0, input int i1, input int icnt,
                       input logic fl, input logic r, input logic zchk);
    int          icEff;
    int          nPush;
    logic        ready;
    logic [1:0]  vExp;
    @(negedge clk);
    ready = (sb.size() <= DEPTH - FETCH_W);
    vExp  = (sb.size() >= 2) ? 2'b11 : ((sb.size() == 1) ? 2'b01 : 2'b00);
    checkVal("count", 32'(count), 32'(sb.size()));
    checkVal("fetch_ready", 32'(fetch_ready), 32'(ready));
    checkVal("issue_valid", 32'(issue_valid), 32'(vExp));
    for (int i = 0; i < ISSUE_W; i++) begin
      if (i < sb.size()) begin
        checkVal($sformatf("instr%0d", i), issue_instr[32*i +: 32], sb[i].instr);
        checkVal($sformatf("pc%0d", i), issue_pc[32*i +: 32], sb[i].pc);
        checkVal($sformatf("ctrl%0d", i), 32'(issue_ctrl[15*i +: 15]), 32'(sb[i].ctrl));
      end
    end
    if (zchk) begin
      checkVal("rstInstr0", issue_instr[31:0], 32'h0);
      checkVal("rstInstr1", issue_instr[63:32], 32'h0);
      checkVal("rstPc0", issue_pc[31:0], 32'h0);
      checkVal("rstPc1", issue_pc[63:32], 32'h0);
      checkVal("rstCtrl", 32'(issue_ctrl), 32'h0);
    end
    icEff = icnt;
    if (icEff > sb.size()) icEff = sb.size();
    if (icEff > ISSUE_W) icEff = ISSUE_W;
    fetch_valid = fv;
    fetch_instr = {tabI[i1], tabI[i0]};
    fetch_pc    = {pcNext + 32'd4, pcNext};
    issue_cnt   = 2'(icEff);
    flush       = fl;
    rst         = r;
    if (r || fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < icEff; k++) void'(sb.pop_front());
      nPush = 0;
      if (ready) nPush = fv[0] ? (fv[1] ? 2 : 1) : 0;
      if (nPush >= 1) sb.push_back('{instr: tabI[i0], pc: pcNext, ctrl: tabC[i0]});
      if (nPush >= 2) sb.push_back('{instr: tabI[i1], pc: pcNext + 32'd4, ctrl: tabC[i1]});
      pcNext = pcNext + 32'(4 * nPush);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() > 0; n++) cycle(2'b00, 0, 0, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Instruction table with hand-derived control words.
    tabI[0]  = 32'h2401_0005; tabC[0]  = 15'h5880; // ADDIU
    tabI[1]  = 32'h8C22_0004; tabC[1]  = 15'h5E80; // LW
    tabI[2]  = 32'h4200_0018; tabC[2]  = 15'h0088; // ERET
    tabI[3]  = 32'h0000_000C; tabC[3]  = 15'h0090; // SYSCALL
    tabI[4]  = 32'hFC00_0000; tabC[4]  = 15'h00C0; // unknown opcode
    tabI[5]  = 32'h0411_0003; tabC[5]  = 15'h6086; // BGEZAL
    tabI[6]  = 32'h7022_1002;                      // MUL
`ifdef DECODE_MUL_EN
    tabC[6]  = 15'h4080;
`else
    tabC[6]  = 15'h00C0;
`endif
    tabI[7]  = 32'h3442_0001; tabC[7]  = 15'h5800; // ORI (zero-extend)
    tabI[8]  = 32'h0022_1821; tabC[8]  = 15'h4080; // ADDU
    tabI[9]  = 32'h1022_0002; tabC[9]  = 15'h0081; // BEQ
    tabI[10] = 32'hAC22_0008; tabC[10] = 15'h0980; // SW
    tabI[11] = 32'h0040_F809; tabC[11] = 15'h6080; // JALR
    tabI[12] = 32'h03E0_0008; tabC[12] = 15'h0080; // JR
    tabI[13] = 32'h4002_6000; tabC[13] = 15'h5080; // MFC0
    tabI[14] = 32'h3C01_1234; tabC[14] = 15'h5800; // LUI
    tabI[15] = 32'h0000_000D; tabC[15] = 15'h00A0; // BREAK

    pcNext      = 32'h0040_0000;
    rst         = 1'b1;
    flush       = 1'b0;
    fetch_valid = 2'b00;
    fetch_instr = '0;
    fetch_pc    = '0;
    issue_cnt   = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkVal("rstCount", 32'(count), 32'd0);
    checkVal("rstValid", 32'(issue_valid), 32'd0);
    checkVal("rstReady", 32'(fetch_ready), 32'd1);
    checkVal("rstInstr", issue_instr[31:0], 32'h0);
    checkVal("rstCtrl", 32'(issue_ctrl), 32'h0);

    // ADDIU + LW in one cycle, then fill to full without issuing.
    cycle(2'b11, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 7, 8, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 9, 10, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 11, 12, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 13, 14, 0, 1'b0, 1'b0, 1'b0); // full: ignored
    cycle(2'b11, 0, 1, 1, 1'b0, 1'b0, 1'b0);   // pop 1, push ignored -> 7
    cycle(2'b11, 2, 3, 0, 1'b0, 1'b0, 1'b0);   // count 7: not ready
    cycle(2'b00, 0, 0, 2, 1'b0, 1'b0, 1'b0);   // -> 5
    cycle(2'b11, 15, 8, 2, 1'b0, 1'b0, 1'b0);  // push 2 + pop 2 -> 5
    // Stream through several pointer wraps.
    for (int k = 0; k < 10; k++) cycle(2'b11, (2*k) % 16, (2*k+1) % 16, 2, 1'b0, 1'b0, 1'b0);
    drain();

    // Exception/reserved encodings, BGEZAL and non-contiguous valid.
    cycle(2'b11, 2, 3, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b10, 5, 5, 0, 1'b0, 1'b0, 1'b0);   // nothing accepted
    cycle(2'b01, 5, 0, 1, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    drain();

    // Count 4, then flush with a simultaneous push and pop.
    cycle(2'b11, 6, 8, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 9, 13, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 0, 1, 2, 1'b1, 1'b0, 1'b0);
    cycle(2'b01, 6, 0, 0, 1'b0, 1'b0, 1'b0);   // MUL after flush
    cycle(2'b00, 0, 0, 1, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream drops entries and clears storage.
    cycle(2'b11, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 15, 11, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 6, 0, 1, 1'b0, 1'b1, 1'b0);
    cycle(2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
